// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC update codes, fetch FSM states and default widths.
package cpu_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 16;

    // PC update codes driven by the controller on pcEn
    localparam logic [1:0] PC_HOLD   = 2'b00;
    localparam logic [1:0] PC_INC    = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_BRANCH = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StDone = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: hold, increment, jump, or branch by a
// sign-extended 8-bit displacement. All arithmetic wraps modulo 2^AddrW.
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int unsigned AddrW = ADDR_W_DEF
) (
    input  logic [AddrW-1:0] pc_i,
    input  logic [1:0]       pc_en_i,
    input  logic [AddrW-1:0] jump_target_i,
    input  logic [7:0]       disp_i,
    output logic [AddrW-1:0] pc_next_o
);

    logic [AddrW-1:0] disp_ext;

    assign disp_ext = {{(AddrW - 8){disp_i[7]}}, disp_i};

    // Select the candidate PC for the requested update code
    always_comb begin
        pc_next_o = pc_i;
        unique case (pc_en_i)
            PC_HOLD:   pc_next_o = pc_i;
            PC_INC:    pc_next_o = pc_i + AddrW'(1);
            PC_JUMP:   pc_next_o = jump_target_i;
            PC_BRANCH: pc_next_o = pc_i + disp_ext;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake into
// the instruction register, and applies the controller's PC update codes.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W       = ADDR_W_DEF,
    parameter int unsigned       DATA_W       = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [DATA_W-1:0] IR_RESET     = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetchReq,
    input  logic [1:0]        pcEn,
    input  logic [ADDR_W-1:0] jumpTarget,
    output logic              memRdReq,
    output logic [ADDR_W-1:0] memAddr,
    input  logic              memRdAck,
    input  logic [DATA_W-1:0] memRdata,
    output logic [DATA_W-1:0] instruction,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] linkAddr,
    output logic              instrValid,
    output logic              fetchBusy,
    output logic              protoErr
);

    fetch_state_t      state_q, state_d;
    logic              pending_q, pending_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] pc_next;

    pc_next_calc #(
        .AddrW (ADDR_W)
    ) u_pc_next_calc (
        .pc_i          (pc_q),
        .pc_en_i       (pcEn),
        .jump_target_i (jumpTarget),
        .disp_i        (ir_q[7:0]),
        .pc_next_o     (pc_next)
    );

    // Next-state logic: PC updates only in IDLE; anything out of protocol is flagged
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        err_d     = err_q;
        unique case (state_q)
            StIdle: begin
                if (pcEn != PC_HOLD) pc_d = pc_next;
                if (memRdAck) err_d = 1'b1;
                if (pending_q) begin
                    // Deferred fetch: PC was updated last cycle, fetch from it now
                    pending_d = 1'b0;
                    state_d   = StReq;
                end else if (fetchReq) begin
                    if (pcEn == PC_HOLD) state_d = StReq;
                    else pending_d = 1'b1;
                end
            end
            StReq: begin
                if (pcEn != PC_HOLD) err_d = 1'b1;
                if (memRdAck) begin
                    ir_d    = memRdata;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (pcEn != PC_HOLD) err_d = 1'b1;
                if (memRdAck) err_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            pending_q <= 1'b0;
            pc_q      <= RESET_VECTOR;
            ir_q      <= IR_RESET;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            err_q     <= err_d;
        end
    end

    assign memRdReq    = (state_q == StReq);
    assign instrValid  = (state_q == StDone);
    assign fetchBusy   = (state_q != StIdle) || pending_q;
    assign memAddr     = pc_q;
    assign pc          = pc_q;
    assign linkAddr    = pc_q + ADDR_W'(1);
    assign instruction = ir_q;
    assign protoErr    = err_q;

endmodule
